dma_copy16: RTL and testbench

Block-copy DMA engine and memory-bus arbiter for the 16-bit CPU system. It sits between the CPU16 core and the single-port RAM. It owns the RAM address, data-out and write lines: the CPU has them by default, and the DMA engine takes them after parking the CPU through its `hold`/`busy` handshake. Once started, it copies `count` words from `src` to `dst`. It hands the bus back to the CPU every `BURST` words so that instruction fetch is never starved.

---
 rtl/dma_copy16.sv | 170 +++++++++++++++++
 tb/tb_dma_copy16.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy16.sv
// Block-copy DMA engine and RAM bus arbiter between the CPU16 core and single-port RAM.
// Optional constant-fill mode is compiled in with DMA_FILL_EN.
module dma_copy16 #(
    parameter int unsigned BURST    = 8,
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] count,
    input  logic        fill,
    output logic        dma_busy,
    output logic        done,
    output logic        cpu_hold,
    input  logic        cpu_busy,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_data_out,
    input  logic        cpu_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data_out,
    output logic        mem_write,
    input  logic [15:0] mem_data_in
);

    typedef enum logic [2:0] {
        StIdle, StReq, StRead, StReadWait, StWrite, StRelease, StDone
    } state_e;

    localparam logic [15:0] BurstLast = 16'(BURST);
    localparam logic [7:0]  WaitLast  = 8'(RAM_WAIT);

    state_e      state_q, state_d;
    logic [15:0] sp_q, sp_d, dp_q, dp_d, rem_q, rem_d, bc_q, bc_d, buf_q, buf_d;
    logic [7:0]  wc_q, wc_d;
    logic        own_dma_q, own_dma_d;
    logic        hold_q;
    logic        fill_mode;
    logic        dma_write;
    logic [15:0] dma_address, dma_data;

`ifdef DMA_FILL_EN
    logic fill_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            fill_q <= fill;
        end
    end

    assign fill_mode = fill_q;
`else
    logic unused_fill;
    assign unused_fill = fill;
    assign fill_mode   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            sp_q      <= '0;
            dp_q      <= '0;
            rem_q     <= '0;
            bc_q      <= '0;
            buf_q     <= '0;
            wc_q      <= '0;
            own_dma_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            dp_q      <= dp_d;
            rem_q     <= rem_d;
            bc_q      <= bc_d;
            buf_q     <= buf_d;
            wc_q      <= wc_d;
            own_dma_q <= own_dma_d;
            hold_q    <= cpu_hold;
        end
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        dp_d    = dp_q;
        rem_d   = rem_q;
        bc_d    = bc_q;
        buf_d   = buf_q;
        wc_d    = wc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (count == 16'd0) begin
                        state_d = StDone;
                    end else begin
                        sp_d    = src;
                        dp_d    = dst;
                        rem_d   = count;
                        bc_d    = '0;
                        state_d = StReq;
                    end
                end
            end
            // busy alone could be stale from before hold rose; require hold seen last cycle too
            StReq: begin
                if (cpu_busy && hold_q) state_d = fill_mode ? StWrite : StRead;
            end
            StRead: begin
                wc_d = 8'd1;
                if (RAM_WAIT == 0) begin
                    buf_d   = mem_data_in;
                    state_d = StWrite;
                end else begin
                    state_d = StReadWait;
                end
            end
            StReadWait: begin
                if (wc_q == WaitLast) begin
                    buf_d   = mem_data_in;
                    state_d = StWrite;
                end else begin
                    wc_d = wc_q + 8'd1;
                end
            end
            StWrite: begin
                if (!fill_mode) sp_d = sp_q + 16'd1;
                dp_d  = dp_q + 16'd1;
                rem_d = rem_q - 16'd1;
                bc_d  = bc_q + 16'd1;
                if (rem_q == 16'd1) begin
                    state_d = StDone;
                end else if (bc_q + 16'd1 == BurstLast) begin
                    state_d = StRelease;
                end else begin
                    state_d = fill_mode ? StWrite : StRead;
                end
            end
            StRelease: begin
                bc_d = '0;
                if (!cpu_busy) state_d = StReq;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        own_dma_d = (state_d == StRead) || (state_d == StReadWait) || (state_d == StWrite);
    end

    always_comb begin
        cpu_hold    = (state_q == StReq) || (state_q == StRead) ||
                      (state_q == StReadWait) || (state_q == StWrite);
        dma_busy    = (state_q != StIdle) && (state_q != StDone);
        done        = (state_q == StDone);
        dma_write   = (state_q == StWrite);
        dma_address = (state_q == StWrite) ? dp_q : sp_q;
        dma_data    = fill_mode ? sp_q : buf_q;
        if (own_dma_q) begin
            mem_address  = dma_address;
            mem_data_out = dma_data;
            mem_write    = dma_write;
        end else begin
            mem_address  = cpu_address;
            mem_data_out = cpu_data_out;
            mem_write    = cpu_write;
        end
    end

endmodule

// File: tb/tb_dma_copy16.sv
// Directed bench for dma_copy16: two instances (BURST 8 and BURST 2) with RAM and parked-CPU models.
`timescale 1ns/1ps
module tb_dma_copy16;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start [N];
    logic [15:0] src, dst, count;
    logic        fill;
    logic        dma_busy [N];
    logic        done [N];
    logic        cpu_hold [N];
    logic        cpu_busy [N];
    logic [15:0] cpu_address, cpu_data_out;
    logic        cpu_write;
    logic [15:0] mem_address [N];
    logic [15:0] mem_data_out [N];
    logic        mem_write [N];
    logic [15:0] mem_data_in [N];

    logic [15:0] ram [N][65536];
    bit          valid [N][65536];
    logic        mon_clr;
    int          cyc = 0;
    logic        hold_prev [N], busy_prev [N], rd_prev [N];
    int          done_cnt [N], hold_fall [N], hold_cyc [N], busy_fall [N];
    int          wr_cnt [N], rd_cnt [N], first_wr [N], last_wr [N], first_rd [N];
    logic [15:0] rd_log [N][8];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dma_copy16 #(.BURST(8), .RAM_WAIT(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .src(src), .dst(dst), .count(count),
        .fill(fill), .dma_busy(dma_busy[0]), .done(done[0]), .cpu_hold(cpu_hold[0]),
        .cpu_busy(cpu_busy[0]), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
        .cpu_write(cpu_write), .mem_address(mem_address[0]), .mem_data_out(mem_data_out[0]),
        .mem_write(mem_write[0]), .mem_data_in(mem_data_in[0])
    );

    dma_copy16 #(.BURST(2), .RAM_WAIT(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .src(src), .dst(dst), .count(count),
        .fill(fill), .dma_busy(dma_busy[1]), .done(done[1]), .cpu_hold(cpu_hold[1]),
        .cpu_busy(cpu_busy[1]), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
        .cpu_write(cpu_write), .mem_address(mem_address[1]), .mem_data_out(mem_data_out[1]),
        .mem_write(mem_write[1]), .mem_data_in(mem_data_in[1])
    );

    function automatic logic [15:0] init_word(input logic [15:0] a);
        case (a)
            16'h0100: return 16'h1111;
            16'h0101: return 16'h2222;
            16'h0102: return 16'h3333;
            16'h0103: return 16'h4444;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    function automatic logic [15:0] rd(input int g, input logic [15:0] a);
        return valid[g][a] ? ram[g][a] : init_word(a);
    endfunction

    // RAM with one registered read stage, CPU that parks one cycle after hold, and monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < N; g++) begin
            mem_data_in[g] <= rd(g, mem_address[g]);
            if (mem_write[g]) begin
                ram[g][mem_address[g]]   <= mem_data_out[g];
                valid[g][mem_address[g]] <= 1'b1;
            end
            cpu_busy[g]  <= !reset ? 1'b1 : cpu_hold[g];
            hold_prev[g] <= cpu_hold[g];
            busy_prev[g] <= cpu_busy[g];
            rd_prev[g]   <= dma_busy[g] && !mem_write[g] && mem_address[g] != cpu_address;
            if (mon_clr) begin
                done_cnt[g] <= 0; hold_fall[g] <= 0; hold_cyc[g] <= 0; busy_fall[g] <= 0;
                wr_cnt[g]   <= 0; rd_cnt[g]    <= 0; first_wr[g] <= 0; last_wr[g]   <= 0;
                first_rd[g] <= 0;
            end else begin
                if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
                if (hold_prev[g] && !cpu_hold[g]) hold_fall[g] <= hold_fall[g] + 1;
                if (cpu_hold[g]) hold_cyc[g] <= hold_cyc[g] + 1;
                if (busy_prev[g] && !cpu_busy[g] && dma_busy[g]) busy_fall[g] <= busy_fall[g] + 1;
                if (mem_write[g] && !cpu_write) begin
                    wr_cnt[g]  <= wr_cnt[g] + 1;
                    last_wr[g] <= cyc;
                    if (wr_cnt[g] == 0) first_wr[g] <= cyc;
                end
                if (dma_busy[g] && !mem_write[g] && mem_address[g] != cpu_address) begin
                    if (rd_cnt[g] == 0) first_rd[g] <= cyc;
                    if (!rd_prev[g] && rd_cnt[g] < 8) begin
                        rd_log[g][rd_cnt[g]] <= mem_address[g];
                        rd_cnt[g] <= rd_cnt[g] + 1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic kick(input int g, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] c, input logic f);
        @(negedge clk);
        src = s; dst = d; count = c; fill = f; start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        for (int i = 0; i < 300 && done_cnt[g] == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
        src = '0; dst = '0; count = '0; fill = 1'b0;
        cpu_address = 16'h0ABC; cpu_data_out = 16'h1357; cpu_write = 1'b0; mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hold", cpu_hold[0], 1'b0);
        check("rst_busy", dma_busy[0], 1'b0);
        check("rst_done", done[0], 1'b0);
        check("rst_mux_addr", mem_address[0], 16'h0ABC);
        check("rst_mux_we", mem_write[1], 1'b0);
        reset = 1'b1;
        mon_clr = 1'b0;

        // basic copy, BURST 8
        clr();
        kick(0, 16'h0100, 16'h0200, 16'd4, 1'b0);
        check("copy_hold_1cyc", cpu_hold[0], 1'b1);
        check("copy_dma_busy", dma_busy[0], 1'b1);
        wait_done(0);
        for (int i = 0; i < 4; i++)
            check("copy_data", rd(0, 16'h0200 + 16'(i)), 32'h1111 * (i + 1));
        check("copy_grant_to_last_wr", last_wr[0] - first_rd[0], 11);
        check("copy_done_once", done_cnt[0], 1);
        check("copy_writes", wr_cnt[0], 4);
        check("copy_hold_drops", hold_fall[0], 1);

        // zero count
        clr();
        kick(0, 16'h0100, 16'h0700, 16'd0, 1'b0);
        check("zero_done_next", done[0], 1'b1);
        check("zero_hold", cpu_hold[0], 1'b0);
        repeat (4) @(negedge clk);
        check("zero_done_once", done_cnt[0], 1);
        check("zero_no_write", wr_cnt[0], 0);
        check("zero_no_hold", hold_cyc[0], 0);

        // burst release, BURST 2
        clr();
        kick(1, 16'h0100, 16'h0400, 16'd5, 1'b0);
        wait_done(1);
        check("burst_hold_drops", hold_fall[1], 3);
        check("burst_cpu_fetch", busy_fall[1], 2);
        check("burst_done_once", done_cnt[1], 1);
        check("burst_writes", wr_cnt[1], 5);
        check("burst_d0", rd(1, 16'h0400), 16'h1111);
        check("burst_d3", rd(1, 16'h0403), 16'h4444);
        check("burst_d4", rd(1, 16'h0404), 16'h5B5E);

        // address wrap
        clr();
        kick(0, 16'hFFFE, 16'h0010, 16'd3, 1'b0);
        wait_done(0);
        check("wrap_reads", rd_cnt[0], 3);
        check("wrap_rd0", rd_log[0][0], 16'hFFFE);
        check("wrap_rd1", rd_log[0][1], 16'hFFFF);
        check("wrap_rd2", rd_log[0][2], 16'h0000);
        check("wrap_d2", rd(0, 16'h0012), 16'h5A5A);

        // fill request (only honoured with DMA_FILL_EN)
        clr();
        kick(0, 16'hA5A5, 16'h0300, 16'd3, 1'b1);
        wait_done(0);
        check("fill_writes", wr_cnt[0], 3);
`ifdef DMA_FILL_EN
        check("fill_no_reads", rd_cnt[0], 0);
        check("fill_back_to_back", last_wr[0] - first_wr[0], 2);
        for (int i = 0; i < 3; i++) check("fill_data", rd(0, 16'h0300 + 16'(i)), 16'hA5A5);
`else
        check("fill_off_reads", rd_cnt[0], 3);
        check("fill_off_d0", rd(0, 16'h0300), 16'hFFFF);
        check("fill_off_d1", rd(0, 16'h0301), 16'hFFFC);
`endif

        // reset during the second write
        clr();
        kick(0, 16'h0500, 16'h0600, 16'd4, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (mem_write[0] && wr_cnt[0] == 1) break;
            @(negedge clk);
        end
        check("rst_mid_reached_w2", mem_write[0], 1'b1);
        reset = 1'b0;
        cpu_write = 1'b1;
        @(negedge clk);
        check("rst_mid_hold", cpu_hold[0], 1'b0);
        check("rst_mid_addr", mem_address[0], 16'h0ABC);
        check("rst_mid_data", mem_data_out[0], 16'h1357);
        check("rst_mid_we", mem_write[0], 1'b1);
        check("rst_mid_done", done[0], 1'b0);
        reset = 1'b1;
        cpu_write = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_no_done", done_cnt[0], 0);
        check("rst_mid_cpu_runs", cpu_busy[0], 1'b0);
        check("rst_mid_idle", dma_busy[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
